pipe_stage_skid_reg: RTL
========================

Name: pipe_stage_skid_reg

Overview:
Parametrised, handshaked pipeline-stage register and the successor to the fixed EX/MEM latch. It carries an arbitrary-width payload between two pipeline stages using valid/ready flow control. An optional 2-entry skid buffer keeps the upstream ready registered. It also supports global freeze (hold), flush/exception squash, and a saturating backpressure counter for performance monitoring.

Parameters:
DATA_W, 64, payload width in bits (>=1)
SKID_EN, 1, 1 = 2-entry skid buffer with registered up_ready; 0 = single entry with combinational ready passthrough
CLEAR_DATA, 1, 1 = zero payload registers on reset/flush; 0 = only clear valid bits
CNT_W, 16, width of the backpressure counter

Ports:
clock_i  in  1  clock, all state updates on rising edge
reset_i  in  1  synchronous, active-low reset
flush_i  in  1  squash all held entries (exception/branch flush)
hold_i  in  1  freeze stage: no accept, no present, state unchanged
up_valid_i  in  1  upstream payload valid
up_ready_o  out  1  stage can accept this cycle
up_data_i  in  DATA_W  upstream payload
dn_valid_o  out  1  payload presented downstream
dn_ready_i  in  1  downstream accepts
dn_data_o  out  DATA_W  presented payload (main entry)
occupancy_o  out  2  number of entries held (0..2; max 1 when SKID_EN=0)
bp_cnt_o  out  CNT_W  saturating count of cycles with dn_valid_o=1 and dn_ready_i=0
bp_cnt_clr_i  in  1  synchronous clear of bp_cnt_o

Behaviour:
- State: main_valid/main_data; skid_valid/skid_data (present only when SKID_EN=1).
- push = up_valid_i & up_ready_o; pop = dn_valid_o & dn_ready_i.
- dn_valid_o = main_valid & ~hold_i; dn_data_o = main_data at all times.
- SKID_EN=1: up_ready_o = ~skid_valid & ~hold_i; skid_valid is a register, so there is no combinational path from dn_ready_i.
- SKID_EN=0: up_ready_o = (~main_valid | dn_ready_i) & ~hold_i.
- Priority per edge: reset > flush > hold > normal.
- Reset (reset_i=0): main_valid=0, skid_valid=0, bp_cnt=0. Payload registers go to 0 if CLEAR_DATA=1. Outputs after reset: dn_valid_o=0, dn_data_o=0 (CLEAR_DATA=1), occupancy_o=0, up_ready_o=~hold_i.
- Flush (flush_i=1, reset_i=1): both valids cleared; payload zeroed if CLEAR_DATA=1. A push in the same cycle is dropped. A pop in the same cycle still completes from the downstream's view, because dn_valid_o/dn_ready_i are combinational that cycle. bp_cnt is not cleared by flush.
- Hold (hold_i=1): no push and no pop are possible (ready/valid both forced low), so all entries are unchanged. bp_cnt does not increment.
- Normal update, SKID_EN=1:
  - main empty, push -> main<=up_data, main_valid=1.
  - main full, pop, no skid, push -> main<=up_data.
  - main full, pop, no skid, no push -> main_valid=0.
  - main full, no pop, push -> skid<=up_data, skid_valid=1.
  - skid full, pop -> main<=skid_data, skid_valid=0 (push impossible since ready=0).
  - skid full, no pop -> unchanged.
- Normal update, SKID_EN=0: push -> main<=up_data, main_valid=1; else pop -> main_valid=0.
- Ordering: strict FIFO; no payload duplicated or lost except by flush.
- Latency: 1 cycle from push to dn_valid_o when the stage was empty. Throughput: 1 item/cycle with dn_ready_i held 1.
- occupancy_o = main_valid + skid_valid, registered.
- bp_cnt:
  - bp_cnt_clr_i=1 -> 0 (wins over increment).
  - Else +1 when dn_valid_o & ~dn_ready_i.
  - Saturates at 2^CNT_W-1; no wrap.

Test Plan:
- Reset mid-stream: fill 2 entries (0xA, 0xB), assert reset_i=0 one cycle -> next cycle dn_valid_o=0, occupancy_o=0, dn_data_o=0, bp_cnt_o=0.
- Streaming, SKID_EN=1, dn_ready_i=1: push 0x1..0x8 back-to-back -> dn_data_o shows 0x1..0x8 on consecutive cycles starting one cycle after first push; up_ready_o constantly 1; occupancy_o stays 1.
- Backpressure: push 0x11, 0x22, 0x33 with dn_ready_i=0 -> 0x11 in main, 0x22 in skid, occupancy_o=2, up_ready_o=0, 0x33 held upstream. Then dn_ready_i=1 -> outputs 0x11, 0x22, 0x33 in order; bp_cnt_o equals the stalled cycle count.
- Flush with simultaneous push: occupancy 2, flush_i=1 and up_valid_i=1 (data 0x44) -> next cycle occupancy_o=0, dn_valid_o=0, 0x44 never appears downstream.
- Hold: occupancy 1 (0x55), hold_i=1 for 3 cycles with dn_ready_i=1 and up_valid_i=1 -> dn_valid_o=0, up_ready_o=0, main still 0x55, bp_cnt_o unchanged; release -> 0x55 popped.
- SKID_EN=0 and saturation (CNT_W=4): main full, dn_ready_i=1, push 0x66 -> same-cycle up_ready_o=1 and main<=0x66. Hold dn_ready_i=0 for 20 cycles -> bp_cnt_o=15; bp_cnt_clr_i pulse -> 0.

Source files
------------

// File: rtl/pipe_stage_skid_reg.sv
// pipe_stage_skid_reg
//   Handshaked pipeline-stage register carrying a DATA_W payload between two
//   stages with valid/ready flow control. With SKID_EN=1 a second (skid) entry
//   absorbs one beat of downstream stall so up_ready_o comes from a register.
//   With SKID_EN=0 the stage is a single entry and ready passes through.
//   Supports freeze (hold), squash (flush) and a saturating stall counter.
//
// Ports
//   clock_i       rising-edge clock
//   reset_i       synchronous active-low reset
//   flush_i       drop every held entry
//   hold_i        freeze: no accept, no present, state unchanged
//   up_valid_i    upstream payload valid
//   up_ready_o    stage can accept this cycle
//   up_data_i     upstream payload
//   dn_valid_o    payload presented downstream
//   dn_ready_i    downstream accepts
//   dn_data_o     presented payload (main entry)
//   occupancy_o   entries held (0..2)
//   bp_cnt_o      saturating count of stalled presentation cycles
//   bp_cnt_clr_i  synchronous clear of bp_cnt_o
module pipe_stage_skid_reg #(
   parameter int unsigned DATA_W     = 64,
   parameter int unsigned SKID_EN    = 1,
   parameter int unsigned CLEAR_DATA = 1,
   parameter int unsigned CNT_W      = 16
) (
   input  logic              clock_i,
   input  logic              reset_i,
   input  logic              flush_i,
   input  logic              hold_i,
   input  logic              up_valid_i,
   output logic              up_ready_o,
   input  logic [DATA_W-1:0] up_data_i,
   output logic              dn_valid_o,
   input  logic              dn_ready_i,
   output logic [DATA_W-1:0] dn_data_o,
   output logic [1:0]        occupancy_o,
   output logic [CNT_W-1:0]  bp_cnt_o,
   input  logic              bp_cnt_clr_i
);

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic              main_valid;
   logic [DATA_W-1:0] main_data;
   logic              skid_valid;
   logic              push;
   logic              pop;
   logic [CNT_W-1:0]  bp_cnt;

   assign dn_valid_o  = main_valid & ~hold_i;
   assign dn_data_o   = main_data;
   assign push        = up_valid_i & up_ready_o;
   assign pop         = dn_valid_o & dn_ready_i;
   assign occupancy_o = {1'b0, main_valid} + {1'b0, skid_valid};
   assign bp_cnt_o    = bp_cnt;

   generate
      if (SKID_EN != 0) begin : g_skid
         logic [DATA_W-1:0] skid_data;

         // Ready depends only on the skid register, never on dn_ready_i.
         assign up_ready_o = ~skid_valid & ~hold_i;

         always_ff @(posedge clock_i) begin
            if (!reset_i || flush_i) begin
               main_valid <= 1'b0;
               skid_valid <= 1'b0;
               if (CLEAR_DATA != 0) begin
                  main_data <= '0;
                  skid_data <= '0;
               end
            end else if (!hold_i) begin
               if (!main_valid) begin
                  // skid is never occupied while main is empty
                  if (push) begin
                     main_data  <= up_data_i;
                     main_valid <= 1'b1;
                  end
               end else if (skid_valid) begin
                  // ready is low here, so only the skid-to-main move can happen
                  if (pop) begin
                     main_data  <= skid_data;
                     skid_valid <= 1'b0;
                  end
               end else if (pop) begin
                  if (push) begin
                     main_data <= up_data_i;
                  end else begin
                     main_valid <= 1'b0;
                  end
               end else if (push) begin
                  skid_data  <= up_data_i;
                  skid_valid <= 1'b1;
               end
            end
         end
      end else begin : g_single
         assign skid_valid = 1'b0;
         assign up_ready_o = (~main_valid | dn_ready_i) & ~hold_i;

         always_ff @(posedge clock_i) begin
            if (!reset_i || flush_i) begin
               main_valid <= 1'b0;
               if (CLEAR_DATA != 0) begin
                  main_data <= '0;
               end
            end else if (!hold_i) begin
               if (push) begin
                  main_data  <= up_data_i;
                  main_valid <= 1'b1;
               end else if (pop) begin
                  main_valid <= 1'b0;
               end
            end
         end
      end
   endgenerate

   // Flush does not clear the counter; clear wins over increment.
   always_ff @(posedge clock_i) begin
      if (!reset_i || bp_cnt_clr_i) begin
         bp_cnt <= '0;
      end else if (dn_valid_o && !dn_ready_i && (bp_cnt != '1)) begin
         bp_cnt <= bp_cnt + CNT_ONE;
      end
   end

endmodule
